// File: rtl/gen_input_seq.sv
// Pattern generator for the backprop board test: drives fixed-point k1/k2 over valid/ready,
// picked from debounced switches or auto-sequenced. Define GEN_INPUT_LOOP_EN for endless auto looping.
module gen_input_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FRAC    = 10,
  parameter int unsigned N_PAT   = 8,
  parameter int unsigned DEB_CYC = 16'd50000,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       SW,
  input  logic             auto_en,
  input  logic             start,
  input  logic             k_ready,
  output logic [WIDTH-1:0] input_k_1,
  output logic [WIDTH-1:0] input_k_2,
  output logic             k_valid,
  output logic [3:0]       pat_idx,
  output logic             busy,
  output logic             done
);

  localparam int          INT_BITS = int'(WIDTH) - int'(FRAC);
  localparam int          DCW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int          GCW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYC - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYC - 1);
  localparam logic [3:0]  LAST_IDX = 4'(N_PAT - 1);
`ifdef GEN_INPUT_LOOP_EN
  localparam bit          LOOP     = 1'b1;
`else
  localparam bit          LOOP     = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, VALID, GAP, DONE} state_t;

  state_t         state;
  logic [3:0]     sw_s1, sw_s2, sw_cand, sw_db, sw_last, idx;
  logic [3:0]     idx_next;
  logic [DCW-1:0] deb_cnt;
  logic [GCW-1:0] gap_cnt;
  logic           pend;

  // Table integer scaled to the output format; integers too wide for the integer field saturate.
  function automatic logic [WIDTH-1:0] pat_word(input logic [3:0] i, input logic second);
    logic [3:0] v;
    case (i)
      4'd0:    v = 4'd8;
      4'd1:    v = second ? 4'd5 : 4'd8;
      4'd2:    v = second ? 4'd8 : 4'd5;
      4'd3:    v = 4'd5;
      4'd4:    v = 4'd6;
      4'd5:    v = 4'd7;
      4'd6:    v = 4'd8;
      4'd7:    v = 4'd9;
      default: v = 4'd0;
    endcase
    if ((32'(v) >> INT_BITS) != 32'd0) return '1;
    return WIDTH'(v) << FRAC;
  endfunction

  assign idx_next = (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;

  // Two-flop synchroniser followed by a stability counter; any change restarts the count.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      sw_cand <= '0;
      sw_db   <= '0;
      deb_cnt <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      if (sw_s2 != sw_cand) begin
        sw_cand <= sw_s2;
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_LAST) begin
        deb_cnt <= deb_cnt + DCW'(1);
      end else begin
        sw_db <= sw_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      sw_last   <= '0;
      pend      <= 1'b1;
      gap_cnt   <= '0;
      input_k_1 <= '0;
      input_k_2 <= '0;
      k_valid   <= 1'b0;
      pat_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!auto_en) begin
            if (pend || sw_db != sw_last) begin
              idx     <= sw_db;
              sw_last <= sw_db;
              pend    <= 1'b0;
              state   <= LOAD;
            end
          end else if (start) begin
            idx   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          input_k_1 <= pat_word(idx, 1'b0);
          input_k_2 <= pat_word(idx, 1'b1);
          pat_idx   <= idx;
          k_valid   <= 1'b1;
          state     <= VALID;
        end
        VALID: begin
          if (k_ready) begin
            k_valid <= 1'b0;
            if (!busy) begin
              state <= IDLE;
            end else if (!auto_en) begin
              // Leaving auto mode mid-sequence abandons it without flagging completion.
              busy  <= 1'b0;
              state <= IDLE;
            end else if (idx == LAST_IDX && !LOOP) begin
              state <= DONE;
            end else if (GAP_CYC == 0) begin
              idx   <= idx_next;
              state <= LOAD;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            idx   <= idx_next;
            state <= LOAD;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_input_seq.sv
// Directed bench for gen_input_seq: a table-driven pattern model plus an expected-index queue
// checked on every valid cycle; define GEN_INPUT_LOOP_EN to exercise the looping build.
module tb_gen_input_seq;

  localparam int WIDTH   = 16;
  localparam int FRAC    = 10;
  localparam int DEB_CYC = 4;
`ifdef GEN_INPUT_LOOP_EN
  localparam int N_PAT   = 3;
`else
  localparam int N_PAT   = 8;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       SW = 4'b0101;
  logic             auto_en = 1'b0;
  logic             start = 1'b0;
  logic             k_ready = 1'b1;
  logic [WIDTH-1:0] k1, k2, g_k1, g_k2;
  logic             k_valid, busy, done, g_valid, g_busy, g_done;
  logic [3:0]       pat_idx, g_idx;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc_n = 0;
  logic [3:0] exp_q[$];
  int         hs_edge[$];
  int         g_hs_edge[$];
  int         done_edge = -1;
  logic       done_q = 1'b0;
  bit         g_rec = 1'b0;

  always #5 clk = ~clk;

  gen_input_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .N_PAT(N_PAT), .DEB_CYC(DEB_CYC), .GAP_CYC(0)) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW), .auto_en(auto_en), .start(start), .k_ready(k_ready),
    .input_k_1(k1), .input_k_2(k2), .k_valid(k_valid), .pat_idx(pat_idx), .busy(busy), .done(done)
  );

  gen_input_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .N_PAT(N_PAT), .DEB_CYC(DEB_CYC), .GAP_CYC(3)) dut_g (
    .clk(clk), .rst_n(rst_n), .SW(SW), .auto_en(auto_en), .start(start), .k_ready(k_ready),
    .input_k_1(g_k1), .input_k_2(g_k2), .k_valid(g_valid), .pat_idx(g_idx), .busy(g_busy), .done(g_done)
  );

  // Reference: integer table scaled by 2^FRAC, saturating when it overflows the integer field.
  function automatic logic [WIDTH-1:0] model_word(input int idx, input bit second);
    int t1[8];
    int t2[8];
    int v;
    t1 = '{8, 8, 5, 5, 6, 7, 8, 9};
    t2 = '{8, 5, 8, 5, 6, 7, 8, 9};
    v  = (idx > 7) ? 0 : (second ? t2[idx] : t1[idx]);
    if (v >= (1 << (WIDTH - FRAC))) return '1;
    return WIDTH'(v * (1 << FRAC));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!k_valid && n < 20) begin
      cyc(1);
      n++;
    end
    check("wait_valid", k_valid, 1'b1);
  endtask

  task automatic ack();
    k_ready = 1'b1;
    cyc(1);
    k_ready = 1'b0;
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Every cycle with k_valid: the presented pattern must be the next expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (k_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", k_valid, 1'b0);
        end else begin
          check("pattern", {pat_idx, k1, k2},
                {exp_q[0], model_word(exp_q[0], 1'b0), model_word(exp_q[0], 1'b1)});
          if (k_ready) begin
            hs_edge.push_back(cyc_n + 1);
            void'(exp_q.pop_front());
          end
        end
      end
      if (done && !done_q) done_edge <= cyc_n;
      if (g_rec && g_valid) begin
        check("g_pattern", {g_idx, g_k1, g_k2},
              {4'(g_hs_edge.size()), model_word(g_hs_edge.size(), 1'b0), model_word(g_hs_edge.size(), 1'b1)});
        if (k_ready) g_hs_edge.push_back(cyc_n + 1);
      end
    end
    done_q <= done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    check("model_p0_k1", model_word(0, 1'b0), 16'h2000);
    check("model_p2_k1", model_word(2, 1'b0), 16'h1400);
    check("model_p2_k2", model_word(2, 1'b1), 16'h2000);
    check("model_p5_k1", model_word(5, 1'b0), 16'h1C00);
    check("model_p7_k2", model_word(7, 1'b1), 16'h2400);
    check("model_p12_k1", model_word(12, 1'b0), 16'h0000);

    // Reset with SW=0101: outputs clear, then pattern 0 (pending) and pattern 5 (debounced).
    cyc(3);
    check("rst_outputs", {k1, k2, k_valid, pat_idx, busy, done}, '0);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd5);
    rst_n = 1'b1;
    drain(40);
    cyc(3);
    check("rst_then_p5", pat_idx, 4'd5);

    // Bouncing switches never settle long enough; the final steady value yields exactly one pattern.
    for (int i = 0; i < 10; i++) begin
      SW = i[0] ? 4'b0011 : 4'b0010;
      cyc(2);
    end
    exp_q.push_back(4'd2);
    SW = 4'b0010;
    n = 0;
    while (!k_valid && n < 40) begin
      cyc(1);
      n++;
    end
    // n-1 = edges from the first edge sampling the new SW to the edge raising k_valid.
    check("manual_latency", n - 1, 2 + DEB_CYC + 2);
    check("manual_p2", {pat_idx, k1, k2}, {4'd2, 16'h1400, 16'h2000});
    drain(10);
    cyc(DEB_CYC + 8);

`ifdef GEN_INPUT_LOOP_EN
    for (int i = 0; i < 7; i++) exp_q.push_back(4'(i % N_PAT));
    k_ready = 1'b0;
    auto_en = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wait_valid();
      if (i == 6) auto_en = 1'b0;
      ack();
      check("loop_done_low", done, 1'b0);
    end
    cyc(2);
    check("loop_end", {busy, done, k_valid}, 3'b000);
`else
    // Auto pass, k_ready high: 8 handshakes two edges apart, done one edge after the last.
    for (int i = 0; i < N_PAT; i++) exp_q.push_back(4'(i));
    hs_edge.delete();
    g_rec = 1'b1;
    auto_en = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("auto_start_busy", {busy, k_valid}, 2'b10);
    cyc(1);
    check("auto_first_valid", {k_valid, pat_idx}, {1'b1, 4'd0});
    drain(40);
    cyc(3);
    check("auto_done", {done, busy}, 2'b10);
    check("auto_last_pat", {k1, k2, pat_idx}, {16'h2400, 16'h2400, 4'd7});
    check("auto_hs_count", hs_edge.size(), N_PAT);
    for (int i = 1; i < hs_edge.size(); i++) check("auto_period", hs_edge[i] - hs_edge[i-1], 2);
    if (hs_edge.size() > 0) check("done_delay", done_edge - hs_edge[hs_edge.size()-1], 1);
    n = 0;
    while (!g_done && n < 100) begin
      cyc(1);
      n++;
    end
    g_rec = 1'b0;
    check("g_done", {g_done, g_busy}, 2'b10);
    check("g_hs_count", g_hs_edge.size(), N_PAT);
    for (int i = 1; i < g_hs_edge.size(); i++) check("g_period", g_hs_edge[i] - g_hs_edge[i-1], 5);

    // Back-pressure on idx 3: pattern held stable until accepted.
    k_ready = 1'b0;
    for (int i = 0; i < N_PAT; i++) exp_q.push_back(4'(i));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_clears_done", {done, busy}, 2'b01);
    for (int i = 0; i < N_PAT; i++) begin
      wait_valid();
      if (i == 3) begin
        for (int h = 0; h < 5; h++) begin
          cyc(1);
          check("hold_idx3", {k_valid, pat_idx, k1, k2}, {1'b1, 4'd3, 16'h1400, 16'h1400});
        end
      end
      ack();
    end
    cyc(3);
    check("bp_done", {done, busy}, 2'b10);
    drain(2);

    // auto_en dropped while idx 4 is presented: handshake completes, sequence abandoned.
    for (int i = 0; i < 5; i++) exp_q.push_back(4'(i));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_valid();
      ack();
    end
    wait_valid();
    auto_en = 1'b0;
    cyc(2);
    check("drop_held", {k_valid, pat_idx}, {1'b1, 4'd4});
    ack();
    cyc(2);
    check("drop_end", {busy, done, k_valid}, 3'b000);
`endif

    // Back in manual mode: a new switch setting is presented.
    exp_q.push_back(4'd7);
    k_ready = 1'b1;
    SW = 4'b0111;
    drain(40);
    check("manual_p7", {pat_idx, k1, k2}, {4'd7, 16'h2400, 16'h2400});

    // Reset while a pattern waits for acceptance aborts it on the next edge.
    k_ready = 1'b0;
    auto_en = 1'b1;
    exp_q.push_back(4'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_valid();
    rst_n = 1'b0;
    cyc(1);
    check("rst_mid_valid", {k_valid, busy, done, pat_idx, k1, k2}, '0);
    exp_q.delete();
    auto_en = 1'b0;
    cyc(2);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd7);
    k_ready = 1'b1;
    rst_n = 1'b1;
    drain(40);
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
